// File: rtl/oam_dma.sv
// oam_dma: sprite DMA that halts the CPU and copies a 256-byte page to the PPU OAM data port
module oam_dma #(
  parameter logic [15:0] DMA_TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR    = 16'h2004
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  output logic        o_cpu_rdy,
  output logic [7:0]  o_cpu_data,
  output logic        o_rw,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  input  logic [7:0]  i_data,
  output logic [2:0]  o_debug_state,
  output logic        o_debug_odd
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t state, state_nxt;
  logic r_odd;
  logic [7:0] r_page, r_idx, r_byte;
  logic trig, pass;
  assign trig = !i_cpu_rw && i_cpu_address == DMA_TRIGGER_ADDR;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      r_odd  <= 1'b0;
      r_page <= 8'h00;
      r_idx  <= 8'h00;
      r_byte <= 8'h00;
    end else begin
      state <= state_nxt;
      r_odd <= ~r_odd;
      if (state == IDLE && trig) begin
        r_page <= i_cpu_data;
        r_idx  <= 8'h00;
      end
      if (state == READ) r_byte <= i_data;
      if (state == WRITE) r_idx <= r_idx + 8'd1;
    end
  end
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = trig ? HALT : IDLE;
      HALT:    state_nxt = r_odd ? READ : ALIGN;
      ALIGN:   state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = r_idx == 8'hFF ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end
  // CPU keeps the bus until the first dummy/real read; HALT still passes it through
  assign pass          = state == IDLE || state == HALT;
  assign o_cpu_rdy     = state == IDLE;
  assign o_rw          = pass ? i_cpu_rw : state != WRITE;
  assign o_address     = pass ? i_cpu_address : state == WRITE ? OAM_DATA_ADDR : {r_page, r_idx};
  assign o_data        = pass ? i_cpu_data : r_byte;
  assign o_cpu_data    = i_data;
  assign o_debug_state = state;
  assign o_debug_odd   = r_odd;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: scoreboard bench; stimulus queues expected DMA bus cycles, a negedge monitor checks them
module tb_oam_dma;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rw;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data;
  logic        cpu_rdy;
  logic [7:0]  cpu_rdata;
  logic        rw;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [2:0]  dbg_state;
  logic        dbg_odd;
  typedef struct packed {logic rw; logic [15:0] a; logic [7:0] d;} bus_t;
  bus_t exp_q[$];
  int   len_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   halt_cnt = 0;
  always #5 clk = ~clk;
  oam_dma dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cpu_rw(cpu_rw), .i_cpu_address(cpu_address),
    .i_cpu_data(cpu_data), .o_cpu_rdy(cpu_rdy), .o_cpu_data(cpu_rdata), .o_rw(rw),
    .o_address(address), .o_data(wdata), .i_data(rdata), .o_debug_state(dbg_state),
    .o_debug_odd(dbg_odd)
  );
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ (a[15:8] == 8'h02 ? 8'h00 : a[15:8]);
  endfunction
  assign rdata = mem(address);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      len_q.delete();
      halt_cnt = 0;
    end else begin
      if (dbg_state >= 3'd2) begin
        if (exp_q.size() == 0) chk("unexpected_dma_cycle", {dbg_state, address}, 0);
        else begin
          bus_t e;
          e = exp_q.pop_front();
          chk("dma_rw", rw, e.rw);
          chk("dma_addr", address, e.a);
          if (!e.rw) chk("dma_wdata", wdata, e.d);
          else chk("cpu_rdata", cpu_rdata, mem(address));
        end
      end
      if (!cpu_rdy) halt_cnt++;
      else if (halt_cnt > 0) begin
        if (len_q.size() == 0) chk("unexpected_halt_len", halt_cnt, 0);
        else chk("halt_len", halt_cnt, len_q.pop_front());
        halt_cnt = 0;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // issue a $4014 write now; HALT parity is the inverse of the current parity
  task automatic trig_now(input logic [7:0] page);
    logic al;
    al = dbg_odd;
    if (al) exp_q.push_back({1'b1, page, 8'h00, 8'h00});
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({1'b1, page, i[7:0], 8'h00});
      exp_q.push_back({1'b0, 16'h2004, mem({page, i[7:0]})});
    end
    len_q.push_back(al ? 514 : 513);
    cpu_rw = 1'b0; cpu_address = 16'h4014; cpu_data = page;
    tick();
    chk("halt_entered", dbg_state, 1);
    chk("halt_rdy", cpu_rdy, 0);
    chk("halt_odd", dbg_odd, !al);
    cpu_rw = 1'b1; cpu_address = 16'h0000; cpu_data = 8'h00;
  endtask
  task automatic trig_align(input logic [7:0] page, input logic want_align);
    for (int i = 0; i < 2 && dbg_odd != want_align; i++) tick();
    trig_now(page);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (!cpu_rdy && n < 600) begin tick(); n++; end
    chk("dma_done_in_time", cpu_rdy, 1);
  endtask
  initial begin
    rst_n = 1'b0; cpu_rw = 1'b1; cpu_address = 16'hC123; cpu_data = 8'h3C;
    #3;
    chk("rst_addr", address, 16'hC123);
    chk("rst_rw", rw, 1);
    chk("rst_wdata", wdata, 8'h3C);
    chk("rst_rdy", cpu_rdy, 1);
    chk("rst_state", dbg_state, 0);
    chk("rst_odd", dbg_odd, 0);
    chk("rst_cpu_rdata", cpu_rdata, mem(16'hC123));
    tick(); tick();
    rst_n = 1'b1;
    cpu_rw = 1'b0; cpu_address = 16'h4015; cpu_data = 8'h55;
    tick();
    chk("write_4015_idle", dbg_state, 0);
    cpu_rw = 1'b1; cpu_address = 16'h4014;
    tick();
    chk("read_4014_idle", dbg_state, 0);
    cpu_rw = 1'b0; cpu_address = 16'h4013; cpu_data = 8'h09;
    tick();
    chk("write_4013_idle", dbg_state, 0);
    cpu_rw = 1'b1;
    trig_align(8'h02, 1'b0);
    wait_idle();
    tick();
    trig_align(8'h02, 1'b1);
    cpu_rw = 1'b0; cpu_address = 16'h4014; cpu_data = 8'h09;
    tick();
    cpu_rw = 1'b1; cpu_address = 16'h0000;
    wait_idle();
    tick();
    trig_align(8'hFF, 1'b0);
    wait_idle();
    trig_now(8'h03);
    wait_idle();
    chk("queue_drained", exp_q.size(), 0);
    trig_now(8'h04);
    for (int n = 0; n < 600 && !(dbg_state == 3'd3 && address == 16'h0464); n++) tick();
    chk("reached_read_100", address, 16'h0464);
    tick();
    chk("write_100_state", dbg_state, 4);
    cpu_rw = 1'b1; cpu_address = 16'hBEEF;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rdy", cpu_rdy, 1);
    chk("async_rst_state", dbg_state, 0);
    chk("async_rst_addr", address, 16'hBEEF);
    chk("async_rst_rw", rw, 1);
    tick();
    rst_n = 1'b1;
    tick();
    trig_now(8'h07);
    wait_idle();
    tick(); tick();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_len_q_empty", len_q.size(), 0);
    chk("final_state", dbg_state, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
